// File: rtl/spectrum_video_pkg.sv
// Shared definitions for the Spectrum screen fetch path.
//   - default window size and flash counter bit
//   - attribute byte field positions
//   - GRB colour indices and the fetch FSM state type
package spectrum_video_pkg;

    localparam int ACTIVE_W_DEF  = 256;
    localparam int ACTIVE_H_DEF  = 192;
    localparam int FLASH_BIT_DEF = 4;

    // attribute byte: FLASH | BRIGHT | PAPER[2:0] | INK[2:0]
    localparam int ATTR_FLASH     = 7;
    localparam int ATTR_BRIGHT    = 6;
    localparam int ATTR_PAPER_LSB = 3;
    localparam int ATTR_INK_LSB   = 0;

    typedef enum logic [2:0] {
        GRB_BLACK   = 3'b000,
        GRB_BLUE    = 3'b001,
        GRB_RED     = 3'b010,
        GRB_MAGENTA = 3'b011,
        GRB_GREEN   = 3'b100,
        GRB_CYAN    = 3'b101,
        GRB_YELLOW  = 3'b110,
        GRB_WHITE   = 3'b111
    } grb_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/spectrum_attr_decode.sv
// Combinational attribute decoder: one pixel bit plus its attribute byte
// into a 4-bit colour index {bright, G, R, B}.
//   pix_bit     in   pixel bit (1 = INK, 0 = PAPER)
//   attr_byte   in   attribute byte
//   flash_phase in   current flash phase; swaps INK/PAPER on FLASH cells
//   color_idx   out  {BRIGHT, selected GRB}
module spectrum_attr_decode
    import spectrum_video_pkg::*;
(
    input  logic       pix_bit,
    input  logic [7:0] attr_byte,
    input  logic       flash_phase,
    output logic [3:0] color_idx
);

    logic [2:0] ink;
    logic [2:0] paper;
    logic       use_ink;

    always_comb begin
        ink       = attr_byte[ATTR_INK_LSB +: 3];
        paper     = attr_byte[ATTR_PAPER_LSB +: 3];
        use_ink   = pix_bit ^ (attr_byte[ATTR_FLASH] & flash_phase);
        color_idx = {attr_byte[ATTR_BRIGHT], (use_ink ? ink : paper)};
    end

endmodule

// File: rtl/spectrum_video_fetch.sv
// Display-side reader for the Spectrum screen RAM. Tracks scan position in
// the active window, prefetches each 8-pixel group in native screen layout
// and turns pixel+attribute bytes into a registered colour index.
//   clk, rst_n             clock, async active-low reset
//   pix_ce                 one-cycle strobe per output pixel
//   active_in              pixel lies in the window (sampled on pix_ce)
//   line_start/frame_start one-cycle timing pulses
//   border                 border colour, GRB
//   addr_r, re             screen RAM pixel address and read pulse
//   pix, attr              RAM data, valid the clk after re
//   color                  {bright, G, R, B}, updated on pix_ce
//
// Fetch FSM
//   state      | meaning
//   ST_IDLE    | no read in flight
//   ST_ISSUE   | re high, addr_r valid
//   ST_CAPTURE | RAM data on pix/attr, latched into pending at end of cycle
module spectrum_video_fetch
    import spectrum_video_pkg::*;
#(
    parameter int ACTIVE_W  = ACTIVE_W_DEF,
    parameter int ACTIVE_H  = ACTIVE_H_DEF,
    parameter int FLASH_BIT = FLASH_BIT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_ce,
    input  logic        active_in,
    input  logic        line_start,
    input  logic        frame_start,
    input  logic [2:0]  border,
    output logic [12:0] addr_r,
    output logic        re,
    input  logic [7:0]  pix,
    input  logic [7:0]  attr,
    output logic [3:0]  color
);

    localparam logic [7:0] X_LAST = 8'(ACTIVE_W - 1);
    localparam logic [4:0] G_LAST = 5'(ACTIVE_W / 8 - 1);

    fetch_state_e state_q, state_d;
    logic [7:0]   x_q, x_d;
    logic [7:0]   y_q, y_d;
    logic [4:0]   fcnt_q, fcnt_d;
    logic         line_act_q, line_act_d;
    logic         over_q, over_d;
    logic         seen_q, seen_d;
    logic [12:0]  addr_q, addr_d;
    logic [7:0]   pend_pix_q, pend_pix_d;
    logic [7:0]   pend_attr_q, pend_attr_d;
    logic [7:0]   shift_q, shift_d;
    logic [7:0]   cur_attr_q, cur_attr_d;
    logic [3:0]   color_q, color_d;

    // Line context with this cycle's line_start/frame_start already applied,
    // so a coincident strobe or group-0 fetch sees the new line.
    logic [7:0]   y_cur;
    logic [7:0]   x_cur;
    logic         over_cur;
    logic         in_rows;
    logic         show;
    logic         load;
    logic         dec_bit;
    logic [7:0]   dec_attr;
    logic [3:0]   dec_color;

    spectrum_attr_decode u_decode (
        .pix_bit     (dec_bit),
        .attr_byte   (dec_attr),
        .flash_phase (fcnt_q[FLASH_BIT]),
        .color_idx   (dec_color)
    );

    always_comb begin
        y_cur = y_q;
        if (frame_start) begin
            y_cur = '0;
        end else if (line_start && line_act_q && (y_q != 8'hFF)) begin
            y_cur = y_q + 8'd1;
        end
        x_cur    = line_start ? 8'd0 : x_q;
        over_cur = line_start ? 1'b0 : over_q;
        in_rows  = ({1'b0, y_cur} < 9'(ACTIVE_H));
        show     = pix_ce & active_in & in_rows & ~over_cur;
        load     = show & (x_cur[2:0] == 3'd0);
        dec_bit  = load ? pend_pix_q[7] : shift_q[7];
        dec_attr = load ? pend_attr_q : cur_attr_q;
    end

    always_comb begin
        x_d         = x_cur;
        y_d         = y_cur;
        over_d      = over_cur;
        fcnt_d      = fcnt_q + {4'd0, frame_start};
        seen_d      = seen_q | frame_start;
        line_act_d  = (line_start | frame_start) ? 1'b0 : line_act_q;
        state_d     = ST_IDLE;
        addr_d      = addr_q;
        pend_pix_d  = pend_pix_q;
        pend_attr_d = pend_attr_q;
        shift_d     = shift_q;
        cur_attr_d  = cur_attr_q;
        color_d     = color_q;

        if (pix_ce && active_in) begin
            line_act_d = 1'b1;
            x_d        = x_cur + 8'd1;
            if (x_cur == X_LAST) begin
                over_d = 1'b1;
            end
        end

        if (show) begin
            shift_d = load ? {pend_pix_q[6:0], 1'b0} : {shift_q[6:0], 1'b0};
            if (load) begin
                cur_attr_d = pend_attr_q;
            end
        end

        if (pix_ce) begin
            color_d = show ? dec_color : {1'b0, border};
        end

        case (state_q)
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                pend_pix_d  = pix;
                pend_attr_d = attr;
            end
            default:    state_d = ST_IDLE;
        endcase

        // Group g+1 is fetched while group g is mid-display (x = 8g+3), which
        // leaves several strobes of slack before it is needed at x = 8g+8.
        if (line_start && (seen_q || frame_start) && in_rows) begin
            state_d = ST_ISSUE;
            addr_d  = {y_cur[7:6], y_cur[2:0], y_cur[5:3], 5'd0};
        end else if (show && seen_q && (x_cur[2:0] == 3'd3) && (x_cur[7:3] < G_LAST)) begin
            state_d = ST_ISSUE;
            addr_d  = {y_cur[7:6], y_cur[2:0], y_cur[5:3], x_cur[7:3] + 5'd1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            fcnt_q      <= '0;
            line_act_q  <= 1'b0;
            over_q      <= 1'b0;
            seen_q      <= 1'b0;
            addr_q      <= '0;
            pend_pix_q  <= '0;
            pend_attr_q <= '0;
            shift_q     <= '0;
            cur_attr_q  <= '0;
            color_q     <= {1'b0, GRB_BLACK};
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            fcnt_q      <= fcnt_d;
            line_act_q  <= line_act_d;
            over_q      <= over_d;
            seen_q      <= seen_d;
            addr_q      <= addr_d;
            pend_pix_q  <= pend_pix_d;
            pend_attr_q <= pend_attr_d;
            shift_q     <= shift_d;
            cur_attr_q  <= cur_attr_d;
            color_q     <= color_d;
        end
    end

    assign re     = (state_q == ST_ISSUE);
    assign addr_r = addr_q;
    assign color  = color_q;

endmodule

// File: doc/spectrum_video_fetch.md
# spectrum_video_fetch

Display-side reader for the dual-ported Spectrum screen RAM. It counts scan position inside the 256x192 active window and issues read addresses in native Spectrum screen layout. It decodes each pixel byte with its attribute byte, including FLASH and BRIGHT, into a 4-bit colour index per pixel for the LCD output stage. It sits between the LCD timing generator (which supplies strobes) and the palette/LCD driver.

## Interface
- ACTIVE_W, 256: active pixels per line.
- ACTIVE_H, 192: active lines per frame.
- FLASH_BIT, 4: frame-counter bit that drives the flash phase (period 2^(FLASH_BIT+1) frames).

- clk  in  1  single clock for all logic.
- rst_n  in  1  reset: asynchronous, active-low.
- pix_ce  in  1  one-cycle strobe per output pixel; strobes are at least 2 clk apart.
- active_in  in  1  current pixel lies inside the window; sampled on pix_ce.
- line_start  in  1  one-cycle pulse per line; at least 3 clk before the line's first active pix_ce.
- frame_start  in  1  one-cycle pulse per frame; precedes that frame's first line_start.
- border  in  3  border colour, GRB.
- addr_r  out  13  screen RAM read address (pixel area).
- re  out  1  screen RAM read enable, one-cycle pulse.
- pix  in  8  pixel byte; valid the clk after re.
- attr  in  8  attribute byte; valid the clk after re.
- color  out  4  {bright, G, R, B}.

## Operation
- Counters:
  - x (8b): cleared on line_start; +1 on each pix_ce with active_in=1.
  - y (8b): cleared on frame_start; +1 on a line_start that follows a line containing at least one active pix_ce.
  - fcnt (5b): +1 on frame_start, wraps at 31.
- Address for group g (0..31) of line y: addr_r = {y[7:6], y[2:0], y[5:3], g[4:0]}. The RAM derives the attribute address itself.
- Fetch schedule (no fetch when y ≥ ACTIVE_H):
  - group 0: re pulses the clk after line_start.
  - group g+1: re pulses the clk after the pix_ce that displays x = 8g+3, for g+1 ≤ 31.
- Capture: pix and attr are latched into pending registers the clk after re.
- Display: at the pix_ce with x[2:0]=0, the pending byte becomes the current byte. Bits are output MSB first.
- Attribute decode: bit7 FLASH, bit6 BRIGHT, [5:3] PAPER, [2:0] INK.
  - Pixel bit 1 selects INK, 0 selects PAPER.
  - If FLASH=1 and fcnt[FLASH_BIT]=1, INK and PAPER swap.
  - color = {BRIGHT, selected}.
- Border: if active_in=0, or y ≥ ACTIVE_H, or the pix_ce falls beyond ACTIVE_W active pixels in a line, color = {1'b0, border}.
- re is 0 at all times other than the scheduled pulses. addr_r holds its last value.

## Timing
- Reset values: color=0, re=0, addr_r=0, x=y=fcnt=0, pending and current bytes 0.
- color is registered. It updates only on the clk edge where pix_ce=1 and is valid from the next clk until the next pix_ce. Latency from strobe to colour is 1 clk.
- RAM read latency is 1 clk. The prefetch lead of at least 8 clk (given pix_ce spacing ≥2) covers it.
- line_start and pix_ce in the same cycle: line_start wins. x clears and that strobe is treated as x=0.
- frame_start and line_start in the same cycle: y=0, and the group-0 fetch uses y=0.
- Reset mid-line: all state clears immediately and color=0. Output resumes correctly from the next frame_start.

## Structure
- Package spectrum_video_pkg holds:
  - ACTIVE_W/ACTIVE_H defaults
  - attribute bit positions (FLASH, BRIGHT, PAPER, INK)
  - the GRB colour-index constants
- Sub-module spectrum_attr_decode: combinational. Inputs: pixel bit, attribute, flash phase. Output: 4-bit colour. The top level holds counters, fetch FSM (IDLE, ISSUE, CAPTURE) and the shift register.

## Test plan
- Reset: assert rst_n=0 mid-line -> color=0, re=0, addr_r=0 within the same cycle; no re until the next frame_start and line_start.
- Line 0, group 0: frame_start, line_start, RAM returns pix=0x81, attr=0x07 -> re one clk after line_start with addr_r=0x0000; the 8 colours are 7,0,0,0,0,0,0,7.
- Address map: line y=65, group 5 -> addr_r=0x0905; y=191, group 31 -> addr_r=0x17FF.
- Flash: attr=0xC2, pix=0xFF -> color=0xA on frames with fcnt=0..15, color=0x8 on frames with fcnt=16..31.
- Border: active_in=0, border=5 -> color=0x5. Lines y ≥ 192 -> no re and border colour. A 257th active strobe -> border.
- Back-to-back strobes at 2-clk spacing for a full line -> exactly 32 re pulses, no missed or stale bytes (scoreboard against a RAM model).
